// File: rtl/hyper_rx_pack.sv
// hyper_rx_pack: packs 16-bit captured DDR halfwords into 32-bit read words.
// Each command carries a halfword count and a start alignment. Halfwords are
// consumed over a valid/ready handshake and packed little-endian: the earlier
// halfword lands in [15:0]. Each packed word carries byte strobes and a last flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; zero-length commands are accepted and dropped
// RUN   | consuming halfwords until the remaining count is exhausted
module hyper_rx_pack #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             cmd_start_odd_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  input  logic [15:0]      rx_data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      data_o,
  output logic [3:0]       strb_o,
  output logic             last_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q;
  logic [LEN_W-1:0] remaining_q;
  logic             half_sel_q;
  logic [15:0]      low_q;
  logic             low_valid_q;

  logic             valid_q;
  logic [31:0]      data_q;
  logic [3:0]       strb_q;
  logic             last_q;

  logic             cmd_fire;
  logic             rx_fire;
  logic             rem_one;
  logic             emit;
  logic [31:0]      emit_data;
  logic [3:0]       emit_strb;

  // A halfword is only taken when the output register is free or draining now,
  // so an emitted word can never be overwritten before it is accepted.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rx_ready_o  = (state_q == ST_RUN) && (!valid_q || ready_i);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign rem_one     = (remaining_q == LEN_W'(1));
  assign emit        = rx_fire && (half_sel_q || rem_one);

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign last_o  = last_q;

  // Word being completed by the current beat: upper-half beat closes a word,
  // a lower-half beat only emits when it is the final halfword.
  always_comb begin
    emit_data = 32'h0;
    emit_strb = 4'b0000;
    if (half_sel_q) begin
      emit_data = {rx_data_i, (low_valid_q ? low_q : 16'h0)};
      emit_strb = low_valid_q ? 4'b1111 : 4'b1100;
    end else begin
      emit_data = {16'h0, rx_data_i};
      emit_strb = 4'b0011;
    end
  end

  // Command sequencing, remaining down-counter and lower-half holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      half_sel_q  <= 1'b0;
      low_q       <= 16'h0;
      low_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire && (cmd_len_i != '0)) begin
            remaining_q <= cmd_len_i;
            half_sel_q  <= cmd_start_odd_i;
            low_valid_q <= 1'b0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rx_fire) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (half_sel_q) begin
              half_sel_q  <= 1'b0;
              low_valid_q <= 1'b0;
              if (rem_one) begin
                state_q <= ST_IDLE;
              end
            end else if (rem_one) begin
              state_q <= ST_IDLE;
            end else begin
              low_q       <= rx_data_i;
              low_valid_q <= 1'b1;
              half_sel_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: loads on emit, holds while stalled, clears on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      strb_q  <= 4'b0000;
      last_q  <= 1'b0;
    end else if (emit) begin
      valid_q <= 1'b1;
      data_q  <= emit_data;
      strb_q  <= emit_strb;
      last_q  <= rem_one;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hyper_rx_pack.sv
// Testbench for hyper_rx_pack: directed cases plus randomized transactions,
// with expected words computed from halfword positions and checked by a monitor.
module tb_hyper_rx_pack;

  localparam int LEN_W  = 16;
  localparam int BUDGET = 500;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } word_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic             cmd_start_odd_i;
  logic             rx_valid_i;
  logic             rx_ready_o;
  logic [15:0]      rx_data_i;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      data_o;
  logic [3:0]       strb_o;
  logic             last_o;

  word_t       exp_q[$];
  logic [15:0] txn_hw[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int          rx_gap_max = 0;

  hyper_rx_pack #(.LEN_W(LEN_W)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_len_i       (cmd_len_i),
    .cmd_start_odd_i (cmd_start_odd_i),
    .rx_valid_i      (rx_valid_i),
    .rx_ready_o      (rx_ready_o),
    .rx_data_i       (rx_data_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .data_o          (data_o),
    .strb_o          (strb_o),
    .last_o          (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: halfword i of a transaction sits at position start_odd+i;
  // word w covers positions 2w (low half) and 2w+1 (high half).
  task automatic build_expected(input int len, input bit odd);
    int nwords;
    int idx;
    word_t w;
    if (len == 0) return;
    nwords = (len + int'(odd) + 1) / 2;
    for (int k = 0; k < nwords; k++) begin
      w = '0;
      idx = 2 * k - int'(odd);
      if (idx >= 0 && idx < len) begin
        w.data[15:0] = txn_hw[idx];
        w.strb[1:0]  = 2'b11;
      end
      idx = 2 * k + 1 - int'(odd);
      if (idx >= 0 && idx < len) begin
        w.data[31:16] = txn_hw[idx];
        w.strb[3:2]   = 2'b11;
      end
      w.last = (k == nwords - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic send_cmd(input int len, input bit odd);
    int cyc = 0;
    cmd_valid_i     = 1'b1;
    cmd_len_i       = LEN_W'(len);
    cmd_start_odd_i = odd;
    forever begin
      @(negedge clk_i);
      if (cmd_ready_o) begin
        @(posedge clk_i); #1;
        break;
      end
      @(posedge clk_i); #1;
      cyc++;
      if (cyc > BUDGET) begin
        n_checks++; n_fail++;
        $display("FAIL cmd_timeout: cmd_ready_o stuck at 0, required 1 within %0d cycles", BUDGET);
        break;
      end
    end
    cmd_valid_i = 1'b0;
    cmd_len_i   = LEN_W'($urandom);
  endtask

  task automatic send_hw(input logic [15:0] d);
    int cyc = 0;
    int gap = (rx_gap_max > 0) ? $urandom_range(0, rx_gap_max) : 0;
    repeat (gap) begin
      @(posedge clk_i); #1;
    end
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    forever begin
      @(negedge clk_i);
      if (rx_ready_o) begin
        @(posedge clk_i); #1;
        break;
      end
      @(posedge clk_i); #1;
      cyc++;
      if (cyc > BUDGET) begin
        n_checks++; n_fail++;
        $display("FAIL rx_timeout: rx_ready_o stuck at 0, required 1 within %0d cycles", BUDGET);
        break;
      end
    end
    rx_valid_i = 1'b0;
    rx_data_i  = 16'($urandom);
  endtask

  task automatic run_txn(input int len, input bit odd);
    build_expected(len, odd);
    send_cmd(len, odd);
    for (int i = 0; i < len; i++) send_hw(txn_hw[i]);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 4 * BUDGET) begin
      @(posedge clk_i);
      cyc++;
    end
    #1;
    chk({name, "_drain_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Downstream ready generator.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'($urandom_range(0, 1));
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: compares each accepted word with the scoreboard and checks
  // that a stalled word is the one still owed.
  always @(negedge clk_i) begin
    word_t e;
    if (rst_ni && valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_word: got data %h strb %b last %b, required no word", data_o, strb_o, last_o);
      end else if (ready_i) begin
        e = exp_q.pop_front();
        chk("word_data", data_o, e.data);
        chk("word_strb", 32'(strb_o), 32'(e.strb));
        chk("word_last", 32'(last_o), 32'(e.last));
      end else begin
        chk("stall_hold_data", data_o, exp_q[0].data);
      end
    end
  end

  initial begin
    rst_ni          = 1'b0;
    cmd_valid_i     = 1'b0;
    cmd_len_i       = '0;
    cmd_start_odd_i = 1'b0;
    rx_valid_i      = 1'b0;
    rx_data_i       = 16'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rx_ready",  32'(rx_ready_o),  32'd0);
    chk("rst_valid",     32'(valid_o),     32'd0);
    chk("rst_data",      data_o,           32'd0);
    chk("rst_strb",      32'(strb_o),      32'd0);
    chk("rst_last",      32'(last_o),      32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Even aligned.
    txn_hw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_txn(4, 1'b0);
    drain("even");
    @(negedge clk_i);
    chk("even_idle", 32'(cmd_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // Odd start, odd length.
    txn_hw = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_txn(3, 1'b1);
    drain("odd");

    // Trailing low half.
    txn_hw = '{16'h0001, 16'h0002, 16'h0003};
    run_txn(3, 1'b0);
    drain("trail");

    // Backpressure after the first emit.
    ready_mode = 2;
    txn_hw = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    fork
      run_txn(4, 1'b0);
    join_none
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);
    chk("bp_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("bp_valid",    32'(valid_o),    32'd1);
    chk("bp_data",     data_o,          32'h66665555);
    @(posedge clk_i); #1;
    ready_mode = 0;
    wait fork;
    drain("bp");

    // Zero length, then len=1 immediately followed by len=2.
    txn_hw = {};
    run_txn(0, 1'b0);
    @(negedge clk_i);
    chk("zero_cmd_ready", 32'(cmd_ready_o), 32'd1);
    repeat (4) @(negedge clk_i);
    chk("zero_no_output", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    txn_hw = '{16'h0101};
    run_txn(1, 1'b0);
    txn_hw = '{16'h0202, 16'h0303};
    run_txn(2, 1'b1);
    drain("b2b");

    // Reset mid-burst; previous word still sits in the output fields.
    send_cmd(4, 1'b0);
    send_hw(16'h9999);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid",     32'(valid_o),     32'd0);
    chk("mrst_data",      data_o,           32'd0);
    chk("mrst_strb",      32'(strb_o),      32'd0);
    chk("mrst_last",      32'(last_o),      32'd0);
    chk("mrst_rx_ready",  32'(rx_ready_o),  32'd0);
    chk("mrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    txn_hw = '{16'hABCD, 16'h1234};
    run_txn(2, 1'b1);
    drain("post_rst");

    // Randomized transactions with random gaps and downstream stalls.
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int len;
      bit odd;
      len = $urandom_range(0, 9);
      odd = 1'($urandom_range(0, 1));
      rx_gap_max = $urandom_range(0, 2);
      txn_hw = {};
      for (int i = 0; i < len; i++) txn_hw.push_back(16'($urandom));
      run_txn(len, odd);
    end
    ready_mode = 0;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
